npu_param_loader: RTL and testbench

- Streaming loader that drives the parallel parameter and input-vector ports of the two-layer NPU top.
- Accepts one signed DATA_WIDTH word per valid/ready beat, in a fixed section order, into a shadow store.
- On a correctly framed load, commits the whole set atomically to output registers, so the NPU never sees a half-updated weight set.
- Sits between the host/DMA word stream and the NPU top.

---
 rtl/npu_pkg.sv | 37 +++
 rtl/npu_param_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_npu_param_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared types and helpers for the NPU parameter loader.
//   section_e   : stream section being filled (W1, B1, W2, B2, VEC)
//   state_e     : loader FSM states
//   total_words : number of words in one correctly framed load
//   idx_width   : counter/index width for an n-entry dimension (at least 1)
// -----------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [2:0] {
        SEC_W1,
        SEC_B1,
        SEC_W2,
        SEC_B2,
        SEC_VEC
    } section_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W1,
        ST_B1,
        ST_W2,
        ST_B2,
        ST_VEC,
        ST_COMMIT
    } state_e;

    function automatic int total_words(input int in_n, input int hidden_n, input int out_n);
        return hidden_n * in_n + hidden_n + out_n * hidden_n + out_n + in_n;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/npu_param_loader.sv
// -----------------------------------------------------------------------------
// npu_param_loader
// Streams one signed word per valid/ready beat into a shadow store in the
// order W1, B1, W2, B2, VEC (row-major, column fastest). A correctly framed
// load (s_last exactly on the final word) is copied to the output registers
// in a single edge; a misframed load is dropped and flags frame_err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (only honoured in IDLE)
//   s_valid/s_ready   word handshake; s_ready depends on FSM state only
//   s_data, s_last    stream word and end-of-frame marker
//   in_vec            committed input vector        [IN_N]
//   weights1          committed layer-1 weights      [HIDDEN_N][IN_N]
//   biases1           committed layer-1 biases       [HIDDEN_N]
//   weights2          committed layer-2 weights      [OUT_N][HIDDEN_N]
//   biases2           committed layer-2 biases       [OUT_N]
//   busy              load in progress, including the commit cycle
//   load_done         one-cycle pulse when the commit takes effect
//   frame_err         sticky framing error, cleared by an accepted start
// -----------------------------------------------------------------------------
module npu_param_loader
    import npu_pkg::*;
#(
    parameter int IN_N       = 2,
    parameter int HIDDEN_N   = 2,
    parameter int OUT_N      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    input  logic                                          s_last,
    output logic [IN_N-1:0][DATA_WIDTH-1:0]               in_vec,
    output logic [HIDDEN_N-1:0][IN_N-1:0][DATA_WIDTH-1:0] weights1,
    output logic [HIDDEN_N-1:0][DATA_WIDTH-1:0]           biases1,
    output logic [OUT_N-1:0][HIDDEN_N-1:0][DATA_WIDTH-1:0] weights2,
    output logic [OUT_N-1:0][DATA_WIDTH-1:0]              biases2,
    output logic                                          busy,
    output logic                                          load_done,
    output logic                                          frame_err
);

    localparam int TOTAL = total_words(IN_N, HIDDEN_N, OUT_N);
    localparam int WW    = idx_width(TOTAL);
    localparam int IW    = idx_width(IN_N);
    localparam int HW    = idx_width(HIDDEN_N);
    localparam int OW    = idx_width(OUT_N);
    localparam int MAXR  = (HIDDEN_N > OUT_N) ? HIDDEN_N : OUT_N;
    localparam int MAXC  = (IN_N > MAXR) ? IN_N : MAXR;
    localparam int RW    = idx_width(MAXR);
    localparam int CW    = idx_width(MAXC);

    // Shadow store (filled by the stream) and committed registers share shapes.
    logic [IN_N-1:0][DATA_WIDTH-1:0]                vec_sh_q, vec_q;
    logic [HIDDEN_N-1:0][IN_N-1:0][DATA_WIDTH-1:0]  w1_sh_q,  w1_q;
    logic [HIDDEN_N-1:0][DATA_WIDTH-1:0]            b1_sh_q,  b1_q;
    logic [OUT_N-1:0][HIDDEN_N-1:0][DATA_WIDTH-1:0] w2_sh_q,  w2_q;
    logic [OUT_N-1:0][DATA_WIDTH-1:0]               b2_sh_q,  b2_q;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [WW-1:0]   word_q, word_d;
    logic            err_q, err_d;
    logic            ready_q, busy_q, done_q;

    section_e        sec;
    state_e          sec_next;
    logic [RW-1:0]   row_last;
    logic [CW-1:0]   col_last;
    logic            beat;
    logic            is_last;
    logic            commit;

    assign beat    = s_valid && ready_q;
    assign is_last = (word_q == WW'(TOTAL - 1));

    // Per-section geometry. Bias and vector sections are single-row.
    always_comb begin
        sec      = SEC_W1;
        sec_next = ST_IDLE;
        row_last = '0;
        col_last = '0;
        case (state_q)
            ST_W1: begin
                sec      = SEC_W1;
                sec_next = ST_B1;
                row_last = RW'(HIDDEN_N - 1);
                col_last = CW'(IN_N - 1);
            end
            ST_B1: begin
                sec      = SEC_B1;
                sec_next = ST_W2;
                col_last = CW'(HIDDEN_N - 1);
            end
            ST_W2: begin
                sec      = SEC_W2;
                sec_next = ST_B2;
                row_last = RW'(OUT_N - 1);
                col_last = CW'(HIDDEN_N - 1);
            end
            ST_B2: begin
                sec      = SEC_B2;
                sec_next = ST_VEC;
                col_last = CW'(OUT_N - 1);
            end
            ST_VEC: begin
                sec      = SEC_VEC;
                sec_next = ST_COMMIT;
                col_last = CW'(IN_N - 1);
            end
            default: ;
        endcase
    end

    // Next-state logic. The word counter gives the framing check directly:
    // s_last must coincide exactly with word TOTAL-1.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        word_d  = word_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_W1;
                    err_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    word_d  = '0;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                if (beat) begin
                    if (s_last != is_last) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        word_d = word_q + 1'b1;
                        if (col_q == col_last) begin
                            col_d = '0;
                            if (row_q == row_last) begin
                                row_d   = '0;
                                state_d = sec_next;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // Control registers; s_ready/busy are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            word_q  <= word_d;
            err_q   <= err_d;
            ready_q <= (state_d != ST_IDLE) && (state_d != ST_COMMIT);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= commit;
        end
    end

    // Shadow store writes. A misframed beat may land here too; it is harmless
    // because the shadow is never committed without a full, correct frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            w1_sh_q  <= '0;
            b1_sh_q  <= '0;
            w2_sh_q  <= '0;
            b2_sh_q  <= '0;
            vec_sh_q <= '0;
        end else if (beat) begin
            case (sec)
                SEC_W1:  w1_sh_q[row_q[HW-1:0]][col_q[IW-1:0]] <= s_data;
                SEC_B1:  b1_sh_q[col_q[HW-1:0]]                <= s_data;
                SEC_W2:  w2_sh_q[row_q[OW-1:0]][col_q[HW-1:0]] <= s_data;
                SEC_B2:  b2_sh_q[col_q[OW-1:0]]                <= s_data;
                default: vec_sh_q[col_q[IW-1:0]]               <= s_data;
            endcase
        end
    end

    // Committed registers: change only on the commit edge or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w1_q  <= '0;
            b1_q  <= '0;
            w2_q  <= '0;
            b2_q  <= '0;
            vec_q <= '0;
        end else if (commit) begin
            w1_q  <= w1_sh_q;
            b1_q  <= b1_sh_q;
            w2_q  <= w2_sh_q;
            b2_q  <= b2_sh_q;
            vec_q <= vec_sh_q;
        end
    end

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign frame_err = err_q;
    assign in_vec    = vec_q;
    assign weights1  = w1_q;
    assign biases1   = b1_q;
    assign weights2  = w2_q;
    assign biases2   = b2_q;

endmodule

// File: tb/tb_npu_param_loader.sv
// -----------------------------------------------------------------------------
// tb_npu_param_loader
// Directed bench for npu_param_loader with IN_N=HIDDEN_N=OUT_N=2, 8-bit words
// (14 words per frame). A table of frame records drives the main loads; a few
// hand-written sequences cover reset mid-frame and start handling.
// -----------------------------------------------------------------------------
module tb_npu_param_loader;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int TOTAL = 14;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      s_valid;
    logic                      s_ready;
    logic [DW-1:0]             s_data;
    logic                      s_last;
    logic [N-1:0][DW-1:0]      in_vec;
    logic [N-1:0][N-1:0][DW-1:0] weights1;
    logic [N-1:0][DW-1:0]      biases1;
    logic [N-1:0][N-1:0][DW-1:0] weights2;
    logic [N-1:0][DW-1:0]      biases2;
    logic                      busy;
    logic                      load_done;
    logic                      frame_err;

    npu_param_loader #(
        .IN_N      (N),
        .HIDDEN_N  (N),
        .OUT_N     (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .in_vec   (in_vec),
        .weights1 (weights1),
        .biases1  (biases1),
        .weights2 (weights2),
        .biases2  (biases2),
        .busy     (busy),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Committed set as expected, in stream order.
    logic [DW-1:0] exp_w [TOTAL];

    typedef struct {
        int base;
        int step;
        int n;
        int last_pos;
        bit gap;
        bit ok;
    } frame_t;

    frame_t tbl [5];

    function automatic logic [DW-1:0] word_of(input int base, input int step, input int i);
        return DW'(base + step * i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                check({tag, " weights1"}, 64'(weights1[r][c]), 64'(exp_w[r*N + c]));
                check({tag, " weights2"}, 64'(weights2[r][c]), 64'(exp_w[6 + r*N + c]));
            end
        end
        for (int i = 0; i < N; i++) begin
            check({tag, " biases1"}, 64'(biases1[i]), 64'(exp_w[4 + i]));
            check({tag, " biases2"}, 64'(biases2[i]), 64'(exp_w[10 + i]));
            check({tag, " in_vec"},  64'(in_vec[i]),  64'(exp_w[12 + i]));
        end
    endtask

    task automatic do_start(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check("start frame_err", 64'(frame_err), 64'd0);
        check("start busy",      64'(busy),      64'd1);
        check("start s_ready",   64'(s_ready),   64'd1);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last, input bit st);
        int budget;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        if (st) start = 1'b1;
        budget = 50;
        while (!s_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!s_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: s_ready=%b, want 1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (st) start = 1'b0;
    endtask

    task automatic send_frame(input int base, input int step, input int n, input int last_pos,
                              input bit gap, input int s1, input int s2);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                @(negedge clk);
                check("gap s_ready", 64'(s_ready), 64'd1);
                check("gap in_vec",  64'(in_vec),  64'({exp_w[13], exp_w[12]}));
            end
            send_word(word_of(base, step, i), (i == last_pos), (i == s1) || (i == s2));
        end
    endtask

    // Called just after the edge that accepted the final word.
    task automatic expect_commit(input int base, input int step, input string tag);
        check({tag, " commit busy"},      64'(busy),      64'd1);
        check({tag, " commit s_ready"},   64'(s_ready),   64'd0);
        check({tag, " commit load_done"}, 64'(load_done), 64'd0);
        check({tag, " pre in_vec"},       64'(in_vec),    64'({exp_w[13], exp_w[12]}));
        for (int i = 0; i < TOTAL; i++) exp_w[i] = word_of(base, step, i);
        @(posedge clk);
        #1;
        check({tag, " load_done"}, 64'(load_done), 64'd1);
        check({tag, " busy idle"}, 64'(busy),      64'd0);
        check({tag, " frame_err"}, 64'(frame_err), 64'd0);
        check_outputs(tag);
        @(posedge clk);
        #1;
        check({tag, " load_done pulse"}, 64'(load_done), 64'd0);
    endtask

    task automatic expect_error(input string tag);
        check({tag, " frame_err"}, 64'(frame_err), 64'd1);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " s_ready"},   64'(s_ready),   64'd0);
        check({tag, " load_done"}, 64'(load_done), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check({tag, " no load_done"}, 64'(load_done), 64'd0);
        end
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{base: 1,   step: 1, n: 14, last_pos: 13, gap: 1'b0, ok: 1'b1};
        tbl[1] = '{base: 60,  step: 1, n: 14, last_pos: -1, gap: 1'b0, ok: 1'b0};
        tbl[2] = '{base: 20,  step: 1, n: 14, last_pos: 13, gap: 1'b0, ok: 1'b1};
        tbl[3] = '{base: 1,   step: 1, n: 14, last_pos: 13, gap: 1'b1, ok: 1'b1};
        tbl[4] = '{base: 255, step: 0, n: 5,  last_pos: 4,  gap: 1'b0, ok: 1'b0};

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        for (int i = 0; i < TOTAL; i++) exp_w[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      64'(busy),      64'd0);
        check("reset s_ready",   64'(s_ready),   64'd0);
        check("reset load_done", 64'(load_done), 64'd0);
        check("reset frame_err", 64'(frame_err), 64'd0);
        check_outputs("reset");
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            do_start(1'b0);
            send_frame(tbl[v].base, tbl[v].step, tbl[v].n, tbl[v].last_pos, tbl[v].gap, -1, -1);
            if (tbl[v].ok) expect_commit(tbl[v].base, tbl[v].step, $sformatf("vec%0d", v));
            else           expect_error($sformatf("vec%0d", v));
            if (v == 0) begin
                check("t1 weights1 packed", 64'(weights1), 64'h0403_0201);
                check("t1 biases2 packed",  64'(biases2),  64'h0c0b);
                check("t1 in_vec packed",   64'(in_vec),   64'h0e0d);
            end
            if (v == 2) begin
                check("t4 biases1 packed",  64'(biases1),  64'h1918);
                check("t4 weights2 packed", 64'(weights2), 64'h1d1c_1b1a);
            end
        end

        // Reset in the middle of a frame.
        do_start(1'b0);
        for (int i = 0; i < 7; i++) send_word(word_of(50, 1, i), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < TOTAL; i++) exp_w[i] = '0;
        check("midrst busy",      64'(busy),      64'd0);
        check("midrst s_ready",   64'(s_ready),   64'd0);
        check("midrst load_done", 64'(load_done), 64'd0);
        check_outputs("midrst");
        do_start(1'b0);
        send_frame(70, 1, TOTAL, 13, 1'b0, -1, -1);
        expect_commit(70, 1, "after_rst");

        // start pulses on words 3 and 10 are ignored while busy.
        do_start(1'b0);
        send_frame(100, 1, TOTAL, 13, 1'b0, 2, 9);
        expect_commit(100, 1, "start_pulse");

        // start held high: next load begins one idle cycle after the commit.
        do_start(1'b1);
        send_frame(120, 1, TOTAL, 13, 1'b0, -1, -1);
        expect_commit(120, 1, "start_held");
        check("held restart busy",    64'(busy),    64'd1);
        check("held restart s_ready", 64'(s_ready), 64'd1);
        start = 1'b0;
        send_frame(140, 1, TOTAL, 13, 1'b0, -1, -1);
        expect_commit(140, 1, "held_second");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
